// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Segment patterns are active-low {a,b,c,d,e,f,g}.
package seg_pkg;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Entry [n] holds the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
        7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// BCD digit to active-low 7-segment pattern; dash overrides blank.
module seg7_encode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        if (dash) begin
            seg = SEG_DASH;
        end else if (blank || digit > 4'd9) begin
            seg = SEG_BLANK;
        end else begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD (sequential double-dabble) converter with multiplexed 7-segment scan.
// Define SEG_LZ_BLANK_EN to blank leading zero digits.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              busy,
    output logic              valid,
    output logic              ovf
);

    localparam int unsigned BCD_W   = 4 * DIGITS + 4;
    localparam int unsigned CNT_W   = $clog2(WIDTH + 1);
    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    cap_q, sh_q, sh_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]    cnt_q;
    logic [4*DIGITS-1:0] disp_q;
    logic                ovf_q;
    logic [SCAN_W-1:0]   scan_q;
    logic [IDX_W-1:0]    idx_q;
    logic [6:0]          seg_q, seg_enc;
    logic [DIGITS-1:0]   an_q;
    logic [3:0]          cur_digit;
    logic                lz_blank, conv_last, scan_wrap;

    assign conv_last = (cnt_q == CNT_W'(WIDTH - 1));
    assign scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (load) state_d = StConv;
            StConv:  if (conv_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy  = (state_q != StIdle);
        valid = (state_q == StDone);
    end

    // One double-dabble step: adjust every nibble, then shift {bcd, shift} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i <= DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q  <= '0;
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: if (load) begin
                    cap_q <= value;
                    sh_q  <= value;
                    bcd_q <= '0;
                    cnt_q <= '0;
                end
                StConv: begin
                    bcd_q <= bcd_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + 1'b1;
                end
                StDone: begin
                    disp_q <= bcd_q[4*DIGITS-1:0];
                    // The compare also catches captures too large for the accumulator.
                    ovf_q  <= (bcd_q[BCD_W-1 -: 4] != 4'd0) || (32'(cap_q) > MAX_VAL);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else begin
            scan_q <= scan_wrap ? '0 : scan_q + 1'b1;
            if (scan_wrap) idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_LZ_BLANK_EN
    // Blank when this digit and every digit above it are zero; digit 0 always shows.
    assign lz_blank = (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
`else
    assign lz_blank = 1'b0;
`endif

    seg7_encode u_encode (
        .digit (cur_digit),
        .blank (lz_blank),
        .dash  (ovf_q),
        .seg   (seg_enc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            seg_q <= seg_enc;
            an_q  <= ~(DIGITS'(1) << idx_q);
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign ovf = ovf_q;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the binary input width (range 4..16).
REQ-002 The block SHALL have parameter DIGITS, default 3, meaning the number of 7-segment digits driven (range 1..5).
REQ-003 The block SHALL have parameter SCAN_DIV, default 1000, meaning the clocks per digit refresh slot (at least 2).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port clk  input  1  is the rising-edge system clock.
REQ-006 Port rst  input  1  is the asynchronous active-high reset.
REQ-007 Port value  input  WIDTH  is the unsigned binary number to display.
REQ-008 Port load  input  1  is a single-cycle strobe that captures value and starts conversion.
REQ-009 Port seg  output  7  carries the active-low segments {a,b,c,d,e,f,g} of the currently scanned digit.
REQ-010 Port an  output  DIGITS  carries the active-low digit enables, where an[0] is the least significant digit.
REQ-011 Port busy  output  1  SHALL be high while a conversion is in progress.
REQ-012 Port valid  output  1  SHALL pulse high for one cycle when the display registers update.
REQ-013 Port ovf  output  1  SHALL be high while the displayed capture exceeds 10^DIGITS-1.

Function
REQ-014 The FSM SHALL have states IDLE, CONV and DONE.
REQ-015 In IDLE, load=1 SHALL capture value, clear the BCD accumulator, set busy and enter CONV.
REQ-016 CONV SHALL run sequential double-dabble for exactly WIDTH cycles; in each cycle, every BCD nibble >=5 gets +3, then {bcd,shift} shifts left by 1.
REQ-017 After WIDTH CONV cycles the FSM SHALL enter DONE, which copies the BCD result to the display registers, pulses valid, clears busy and returns to IDLE.
REQ-018 valid SHALL assert exactly WIDTH+1 cycles after the load cycle.
REQ-019 load SHALL be ignored while busy=1, and the in-flight conversion SHALL be unaffected.
REQ-020 The BCD accumulator SHALL be 4*DIGITS+4 bits wide; a nonzero top nibble or any value >10^DIGITS-1 SHALL set ovf in DONE.
REQ-021 While ovf=1, every digit SHALL display a dash (seg=1111110).
REQ-022 Digit patterns SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; blank=1111111.
REQ-023 A scan counter SHALL count 0..SCAN_DIV-1 continuously; on wrap, the digit index SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-024 Exactly one an bit SHALL be low at any time after reset; seg SHALL be registered and aligned with an in the same cycle.
REQ-025 Scanning SHALL continue during CONV and show the previous display contents until DONE.

Reset
REQ-026 While rst=1: state=IDLE, busy=0, valid=0, ovf=0, display registers=0, scan counter=0, digit index=0, seg=1111111, an all ones.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion and discard the partial result.
REQ-028 The first scan slot after reset release SHALL select digit 0 on the first clock edge.

Configuration
REQ-029 With SEG_LZ_BLANK_EN defined, leading zero digits above the most significant nonzero digit SHALL show blank; digit 0 SHALL always show, so value 0 displays "0".
REQ-030 Without SEG_LZ_BLANK_EN, all digits SHALL show their decimal pattern, including leading zeros.

Structure
REQ-031 Package seg_pkg SHALL hold the FSM state enum, the constants SEG_BLANK and SEG_DASH, and the 10-entry digit-pattern constant table.
REQ-032 A combinational sub-module seg7_encode SHALL map a 4-bit BCD digit plus blank/dash controls to the 7-bit pattern; it is instantiated once on the scan path.

Verification
REQ-033 With WIDTH=8, DIGITS=3: load value=255 -> valid 9 cycles later; digits 2,5,5 give seg 0010010/0100100/0100100; ovf=0.
REQ-034 With WIDTH=8, DIGITS=2: load value=100 -> ovf=1 and both digits show 1111110; then load value=99 -> ovf=0 and digits show 9,9.
REQ-035 With SCAN_DIV=4, DIGITS=3: the an sequence is 110,101,011,110, each held for exactly 4 cycles.
REQ-036 With value=7 and SEG_LZ_BLANK_EN defined: digits 2..0 show 1111111, 1111111, 0001111; without the macro they show 0000001, 0000001, 0001111.
REQ-037 Load 200, then load 50 on cycle 3 while busy -> the second load is ignored and the display shows 200.
REQ-038 Assert rst at CONV cycle 4 -> busy=0 and seg=1111111 immediately; no valid pulse occurs; display registers are 0.
